pagerank_row_accum: RTL and testbench
=====================================

Name: pagerank_row_accum

Overview:
Compute stage directly downstream of the PageRank scheduler. It holds the current rank vector R (up to nrows entries) and consumes G-matrix rows streamed two words per beat, matching the scheduler's two memory ports. For each row it produces the dot product with R as one new rank value and returns it to the scheduler for write-back. Arithmetic is unsigned Q16.16 fixed point.

Parameters:
nbits, 32, data width of G, R and result words
nrows, 8, maximum vector length / R register count
frac, 16, fractional bits of the fixed-point format

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin a pass; sampled only in IDLE
size  in  4  vector length for this pass, 0..nrows; values above nrows are clamped to nrows
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at the end of a pass
r_wr_en  in  1  R register write strobe; honoured only in IDLE
r_wr_idx  in  3  R register index
r_wr_data  in  nbits  R register data
g_val  in  1  G beat valid
g_rdy  out  1  G beat ready
g_data0  in  nbits  G[row][col]
g_data1  in  nbits  G[row][col+1]
out_val  out  1  result valid
out_rdy  in  1  result ready
out_idx  out  3  row index of result
out_data  out  nbits  new R[row]

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; R regs, acc, row, col, out_data and out_idx = 0.
  - busy, done, g_rdy and out_val = 0.
- States: IDLE, ACCUM, EMIT, DONE.
- IDLE:
  - r_wr_en writes R[r_wr_idx] at the clock edge.
  - On start, latch the clamped size and clear row, col and acc.
  - size==0 -> DONE; otherwise -> ACCUM.
  - If start and r_wr_en are both high in the same cycle, the write still takes effect.
- ACCUM:
  - g_rdy=1. Only beats with g_val&&g_rdy are accepted.
  - On each accepted beat:
    - acc += p0 + p1, where pk = (g_datak * R[col+k])[frac+nbits-1:frac].
    - Product is 2*nbits wide; sums wrap modulo 2^nbits.
    - Lane 1 contributes 0 when col+1 >= size (odd size).
    - col += 2.
  - When the updated col >= size:
    - out_data = the new acc value, out_idx = row.
    - -> EMIT, effective the next cycle.
  - Latency: out_val rises one cycle after the last beat of a row is accepted.
- EMIT:
  - out_val=1, g_rdy=0; out_data and out_idx are held stable until accepted.
  - On out_rdy: clear acc and col.
  - If row==size-1 -> DONE; otherwise row += 1 -> ACCUM.
- DONE:
  - done=1 for exactly one cycle, then -> IDLE. out_val=0.
- start is ignored outside IDLE. r_wr_en is ignored outside IDLE, so R is stable for the whole pass.
- No beat is accepted in EMIT or DONE; upstream stalls on g_rdy=0.
- Reset asserted mid-pass aborts immediately: no done pulse, and the partial result is discarded.

Decomposition:
- Shared package pagerank_pkg:
  - FSM state enum.
  - Q16.16 constants (FIX_ONE=32'h0001_0000).
  - nrows index width.
- One sub-module, pagerank_fxmul: combinational nbits x nbits unsigned multiply with frac-shift truncation. It is instantiated twice, once per lane.

Test Plan:
- Basic 2x2: R={0x10000,0x20000}, size=2, start; row0 beat (0x8000,0x8000), row1 beat (0x10000,0) -> results (idx0, 0x18000) then (idx1, 0x10000); done pulses once, one cycle after the second out handshake.
- Odd size: size=3, R={0x10000,0x10000,0x10000}; each row sends 2 beats, the second with g_data1=0xFFFFFFFF -> lane 1 is masked and each result = g0+g1+g2 of the valid columns only.
- Backpressure: hold out_rdy=0 for 5 cycles in EMIT -> out_val, out_data and out_idx stay stable and g_rdy=0 throughout; the row advances only on the cycle out_rdy=1.
- Wrap: R[0]=0x7FFF0000, G=0x00020000 -> out_data=0xFFFE0000. A second accumulation of another 0x00020000 in lane 1 against R[1]=0x10000 -> 0x00000000 (modulo wrap).
- Guards: start or r_wr_en pulsed during ACCUM -> no effect on state or R. size=0 -> done pulses with no out_val. size=12 -> treated as 8 rows/columns.
- Async reset: drop reset mid-ACCUM between clock edges -> outputs clear immediately. After release, a new pass with fresh R produces correct results with no stale acc.

Source files
------------

// File: rtl/pagerank_pkg.sv
// -----------------------------------------------------------------------------
// pagerank_pkg
// Shared definitions for the PageRank row-accumulate stage: FSM state type,
// Q16.16 constants and index/size widths used by the RTL and the bench.
// -----------------------------------------------------------------------------
package pagerank_pkg;

  localparam int NBITS  = 32;
  localparam int NROWS  = 8;
  localparam int FRAC   = 16;

  // Width of an R register / row index (3 bits for 8 entries).
  localparam int IDX_W  = $clog2(NROWS);
  // Width of the size port; must hold 0..NROWS and the out-of-range values
  // that get clamped.
  localparam int SIZE_W = 4;

  localparam logic [NBITS-1:0] FIX_ONE  = 32'h0001_0000;
  localparam logic [NBITS-1:0] FIX_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pagerank_fxmul.sv
// -----------------------------------------------------------------------------
// pagerank_fxmul
// Combinational unsigned fixed-point multiply. The full 2*nbits product is
// formed and the window [frac+nbits-1:frac] is returned, i.e. the product is
// rescaled back to the operand format with truncation (no rounding, no
// saturation -- integer overflow bits are simply dropped).
//
// Ports:
//   a, b : nbits-wide unsigned operands
//   p    : nbits-wide rescaled product
// -----------------------------------------------------------------------------
module pagerank_fxmul #(
  parameter int nbits = 32,
  parameter int frac  = 16
) (
  input  logic [nbits-1:0] a,
  input  logic [nbits-1:0] b,
  output logic [nbits-1:0] p
);

  localparam int PW = 2 * nbits;

  // Cast straight out of the shifted product so no partially-used
  // intermediate vector is left hanging around.
  assign p = nbits'((PW'(a) * PW'(b)) >> frac);

endmodule

// File: rtl/pagerank_row_accum.sv
// -----------------------------------------------------------------------------
// pagerank_row_accum
// Holds the rank vector R and computes, for each G-matrix row streamed in two
// words per beat, the dot product G[row] . R in unsigned Q16.16. Each row's
// result is handed back with its row index over a valid/ready interface.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   start, size         : begin a pass of 'size' rows/columns (clamped to nrows)
//   busy, done          : busy outside IDLE; done pulses once per finished pass
//   r_wr_en/idx/data    : R register write port, only honoured in IDLE
//   g_val, g_rdy        : G beat handshake
//   g_data0, g_data1    : G[row][col], G[row][col+1]
//   out_val, out_rdy    : result handshake
//   out_idx, out_data   : row index and new R[row]
//
// FSM states:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; R writable
//   ST_ACCUM | accepting G beats for the current row, accumulating into acc
//   ST_EMIT  | row result presented on out_*, waiting for out_rdy
//   ST_DONE  | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module pagerank_row_accum
  import pagerank_pkg::*;
#(
  parameter int nbits = NBITS,
  parameter int nrows = NROWS,
  parameter int frac  = FRAC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  output logic              busy,
  output logic              done,
  input  logic              r_wr_en,
  input  logic [IDX_W-1:0]  r_wr_idx,
  input  logic [nbits-1:0]  r_wr_data,
  input  logic              g_val,
  output logic              g_rdy,
  input  logic [nbits-1:0]  g_data0,
  input  logic [nbits-1:0]  g_data1,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [IDX_W-1:0]  out_idx,
  output logic [nbits-1:0]  out_data
);

  state_e              state_q, state_d;
  logic [nbits-1:0]    r_q [nrows];
  logic [nbits-1:0]    r_d [nrows];
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [IDX_W-1:0]    row_q, row_d;
  logic [SIZE_W-1:0]   col_q, col_d;
  logic [nbits-1:0]    acc_q, acc_d;
  logic [nbits-1:0]    out_data_q, out_data_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;

  logic [SIZE_W-1:0]   size_clamped;
  logic [SIZE_W-1:0]   col_lane1;
  logic                lane1_en;
  logic [nbits-1:0]    r_lane0, r_lane1;
  logic [nbits-1:0]    prod0, prod1;
  logic                last_row;

  assign size_clamped = (size > SIZE_W'(nrows)) ? SIZE_W'(nrows) : size;

  // Lane 1 points one column past lane 0. On the final beat of an odd-sized
  // row it falls off the end of the vector; forcing its R operand to zero
  // makes that lane contribute nothing regardless of g_data1.
  assign col_lane1 = col_q + SIZE_W'(1);
  assign lane1_en  = (col_lane1 < size_q);
  assign r_lane0   = r_q[col_q[IDX_W-1:0]];
  assign r_lane1   = lane1_en ? r_q[col_lane1[IDX_W-1:0]] : '0;

  pagerank_fxmul #(
    .nbits (nbits),
    .frac  (frac)
  ) u_mul0 (
    .a (g_data0),
    .b (r_lane0),
    .p (prod0)
  );

  pagerank_fxmul #(
    .nbits (nbits),
    .frac  (frac)
  ) u_mul1 (
    .a (g_data1),
    .b (r_lane1),
    .p (prod1)
  );

  assign last_row = ({1'b0, row_q} == (size_q - SIZE_W'(1)));

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    size_d     = size_q;
    row_d      = row_q;
    col_d      = col_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        // A write coinciding with start still lands; the pass then sees it.
        if (r_wr_en) begin
          r_d[r_wr_idx] = r_wr_data;
        end
        if (start) begin
          size_d  = size_clamped;
          row_d   = '0;
          col_d   = '0;
          acc_d   = '0;
          state_d = (size_clamped == '0) ? ST_DONE : ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (g_val) begin
          acc_d = acc_q + prod0 + prod1;
          col_d = col_q + SIZE_W'(2);
          if (col_d >= size_q) begin
            out_data_d = acc_d;
            out_idx_d  = row_q;
            state_d    = ST_EMIT;
          end
        end
      end

      ST_EMIT: begin
        if (out_rdy) begin
          acc_d = '0;
          col_d = '0;
          if (last_row) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + IDX_W'(1);
            state_d = ST_ACCUM;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      size_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      for (int i = 0; i < nrows; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      row_q      <= row_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      for (int i = 0; i < nrows; i++) begin
        r_q[i] <= r_d[i];
      end
    end
  end

  // Handshake/status outputs are pure state decodes, so they drop together
  // with the state register on an asynchronous reset.
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign g_rdy    = (state_q == ST_ACCUM);
  assign out_val  = (state_q == ST_EMIT);
  assign out_idx  = out_idx_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_pagerank_row_accum.sv
module tb_pagerank_row_accum;
  import pagerank_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  size = '0;
  logic        busy, done;
  logic        r_wr_en = 1'b0;
  logic [2:0]  r_wr_idx = '0;
  logic [31:0] r_wr_data = '0;
  logic        g_val = 1'b0;
  logic        g_rdy;
  logic [31:0] g_data0 = '0;
  logic [31:0] g_data1 = '0;
  logic        out_val;
  logic        out_rdy = 1'b1;
  logic [2:0]  out_idx;
  logic [31:0] out_data;

  pagerank_row_accum dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .size      (size),
    .busy      (busy),
    .done      (done),
    .r_wr_en   (r_wr_en),
    .r_wr_idx  (r_wr_idx),
    .r_wr_data (r_wr_data),
    .g_val     (g_val),
    .g_rdy     (g_rdy),
    .g_data0   (g_data0),
    .g_data1   (g_data1),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] data;
  } res_t;

  logic [31:0] m_r   [8];
  logic [31:0] g_mat [8][8];
  res_t        exp_q [$];

  int n_checks      = 0;
  int n_fail        = 0;
  int neg_cnt       = 0;
  int done_due      = -10;
  int stall_left    = 0;
  int outval_cycles = 0;
  bit chk_en        = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Q16.16 product: real-valued a*b, truncated back to 16 fractional bits,
  // integer part kept modulo 2^16.
  function automatic logic [31:0] q_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[47:16];
  endfunction

  // Expected results of a pass: one dot product per row over the first sz
  // columns only, summed modulo 2^32.
  task automatic model_push(input int sz_in);
    int sz;
    logic [31:0] acc;
    sz = (sz_in > 8) ? 8 : sz_in;
    for (int r = 0; r < sz; r++) begin
      acc = '0;
      for (int c = 0; c < sz; c++) acc = acc + q_mul(g_mat[r][c], m_r[c]);
      exp_q.push_back('{idx: 3'(r), data: acc});
    end
  endtask

  // Compare process: every cycle with checking enabled.
  always @(negedge clk) begin
    neg_cnt++;
    if (chk_en) begin
      check("done_timing", done, (neg_cnt == done_due));
      if (out_val) begin
        outval_cycles++;
        check("emit_g_rdy_low", g_rdy, 0);
        check("emit_busy", busy, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_out_val", out_val, 0);
        end else begin
          check("out_idx", out_idx, exp_q[0].idx);
          check("out_data", out_data, exp_q[0].data);
          if (out_rdy) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) done_due = neg_cnt + 1;
          end
        end
      end
    end
  end

  // Result-side backpressure: hold out_rdy low for stall_left EMIT cycles.
  always @(posedge clk) begin
    #1;
    if (out_val && stall_left > 0) begin
      out_rdy = 1'b0;
      stall_left--;
    end else begin
      out_rdy = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_r(input int idx, input logic [31:0] d);
    r_wr_en   = 1'b1;
    r_wr_idx  = 3'(idx);
    r_wr_data = d;
    tick();
    r_wr_en   = 1'b0;
    m_r[idx]  = d;
  endtask

  task automatic wait_accept();
    bit ok;
    int t;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = g_rdy;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) check("g_accept_timeout", ok, 1);
  endtask

  task automatic run_pass(input int sz_in, input int gap, input int stall, input bit guard);
    int sz;
    int t;
    sz = (sz_in > 8) ? 8 : sz_in;
    outval_cycles = 0;
    stall_left    = stall;
    size  = 4'(sz_in);
    start = 1'b1;
    if (sz == 0) done_due = neg_cnt + 2;
    tick();
    start = 1'b0;
    if (guard) begin
      start     = 1'b1;
      size      = 4'd0;
      r_wr_en   = 1'b1;
      r_wr_idx  = 3'd0;
      r_wr_data = 32'hDEAD_0000;
      tick();
      start   = 1'b0;
      r_wr_en = 1'b0;
      size    = 4'(sz_in);
    end
    for (int r = 0; r < sz; r++) begin
      for (int b = 0; b < (sz + 1) / 2; b++) begin
        if (gap != 0) begin
          g_val = 1'b0;
          tick();
        end
        g_val   = 1'b1;
        g_data0 = g_mat[r][2*b];
        g_data1 = (2*b + 1 < sz) ? g_mat[r][2*b+1] : 32'hFFFF_FFFF;
        wait_accept();
      end
      g_val = 1'b0;
    end
    g_val = 1'b0;
    t = 0;
    while ((exp_q.size() != 0 || neg_cnt <= done_due) && t < 300) begin
      tick();
      t++;
    end
    check("pass_results_drained", exp_q.size(), 0);
    check("outval_cycles", outval_cycles, sz + ((sz > 0) ? stall : 0));
    check("idle_after_pass", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_r[i] = '0;
      for (int j = 0; j < 8; j++) g_mat[i][j] = '0;
    end

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_g_rdy", g_rdy, 0);
    check("rst_out_val", out_val, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    reset = 1'b1;
    tick();
    chk_en = 1'b1;

    // Basic 2x2
    write_r(0, FIX_ONE);
    write_r(1, 32'h0002_0000);
    g_mat[0][0] = 32'h8000;  g_mat[0][1] = 32'h8000;
    g_mat[1][0] = 32'h10000; g_mat[1][1] = 32'h0;
    model_push(2);
    check("pin_basic_row0", exp_q[0].data, 32'h0001_8000);
    check("pin_basic_row1", exp_q[1].data, 32'h0001_0000);
    run_pass(2, 0, 0, 0);

    // Backpressure: 5 stalled EMIT cycles on the first row
    model_push(2);
    run_pass(2, 0, 5, 0);

    // Odd size: lane 1 of the second beat carries 0xFFFFFFFF and must be ignored
    for (int i = 0; i < 3; i++) write_r(i, FIX_ONE);
    g_mat[0][0] = 32'h10000; g_mat[0][1] = 32'h20000; g_mat[0][2] = 32'h30000;
    g_mat[1][0] = 32'h8000;  g_mat[1][1] = 32'h8000;  g_mat[1][2] = 32'h8000;
    g_mat[2][0] = 32'h1;     g_mat[2][1] = 32'h2;     g_mat[2][2] = 32'h3;
    model_push(3);
    check("pin_odd_row0", exp_q[0].data, 32'h0006_0000);
    check("pin_odd_row1", exp_q[1].data, 32'h0001_8000);
    check("pin_odd_row2", exp_q[2].data, 32'h0000_0006);
    run_pass(3, 1, 0, 0);

    // Wrap
    write_r(0, 32'h7FFF_0000);
    g_mat[0][0] = 32'h0002_0000;
    model_push(1);
    check("pin_wrap_single", exp_q[0].data, 32'hFFFE_0000);
    run_pass(1, 0, 0, 0);
    write_r(1, FIX_ONE);
    g_mat[0][0] = 32'h0002_0000; g_mat[0][1] = 32'h0002_0000;
    g_mat[1][0] = 32'h0;         g_mat[1][1] = 32'h0003_0000;
    model_push(2);
    check("pin_wrap_mod", exp_q[0].data, 32'h0000_0000);
    check("pin_wrap_row1", exp_q[1].data, 32'h0003_0000);
    run_pass(2, 0, 0, 0);

    // Guards: start/r_wr_en/size wiggled during ACCUM
    model_push(2);
    run_pass(2, 0, 0, 1);

    // size = 0: done only
    run_pass(0, 0, 0, 0);

    // size = 12 clamps to 8
    for (int i = 0; i < 8; i++) write_r(i, 32'((i + 1) << 16));
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) g_mat[r][c] = 32'((r + 1) << 16);
    model_push(12);
    check("pin_big_row0", exp_q[0].data, 32'h0024_0000);
    check("pin_big_row7", exp_q[7].data, 32'h0120_0000);
    run_pass(12, 0, 0, 0);

    // Async reset mid-ACCUM
    size  = 4'd4;
    start = 1'b1;
    tick();
    start   = 1'b0;
    g_val   = 1'b1;
    g_data0 = 32'h0001_0000;
    g_data1 = 32'h0001_0000;
    wait_accept();
    g_val = 1'b0;
    check("pre_reset_busy", busy, 1);
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_g_rdy", g_rdy, 0);
    check("async_out_val", out_val, 0);
    check("async_done", done, 0);
    check("async_out_data", out_data, 0);
    check("async_out_idx", out_idx, 0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    tick(); tick();
    reset = 1'b1;
    done_due = -10;
    tick();
    chk_en = 1'b1;

    // Fresh pass: only R[0] written, R[1] must read back as zero
    write_r(0, FIX_ONE);
    g_mat[0][0] = 32'h0001_0000; g_mat[0][1] = 32'h0005_0000;
    g_mat[1][0] = 32'h0002_0000; g_mat[1][1] = 32'h0007_0000;
    model_push(2);
    check("pin_post_reset_row0", exp_q[0].data, 32'h0001_0000);
    check("pin_post_reset_row1", exp_q[1].data, 32'h0002_0000);
    run_pass(2, 0, 0, 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
